// File: rtl/fix_msg_tx_pkg.sv
// Shared definitions for the FIX session-message serializer.
// The FIX_LOGON_HBINT_EN macro adds the logon EncryptMethod/HeartBtInt segment.
package fix_msg_tx_pkg;

    localparam logic [7:0] SOH = 8'h01;

    localparam logic [3:0] MSG_HEARTBEAT = 4'h0;
    localparam logic [3:0] MSG_RESEND    = 4'h2;
    localparam logic [3:0] MSG_LOGOUT    = 4'h5;
    localparam logic [3:0] MSG_LOGON     = 4'hA;

    localparam int IDX_W      = 5;
    localparam int BEGIN_LEN  = 12;
    localparam int HBINT_LEN  = 13;
    localparam int BODY_FIXED = 23;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CALC,
        ST_BEGIN,
        ST_BLEN,
        ST_TYPE,
        ST_SENDER,
        ST_TARGET,
        ST_SEQ,
`ifdef FIX_LOGON_HBINT_EN
        ST_HBINT,
`endif
        ST_CKCALC,
        ST_CKSUM
    } state_t;

    localparam logic [7:0] BEGIN_STR [BEGIN_LEN] =
        '{"8", "=", "F", "I", "X", ".", "4", ".", "2", SOH, "9", "="};
    localparam logic [7:0] HBINT_STR [HBINT_LEN] =
        '{"9", "8", "=", "0", SOH, "1", "0", "8", "=", "0", "3", "0", SOH};

    function automatic logic type_valid(input logic [3:0] t);
        return (t == MSG_HEARTBEAT) || (t == MSG_RESEND) ||
               (t == MSG_LOGOUT) || (t == MSG_LOGON);
    endfunction

    function automatic logic [7:0] msg_type_char(input logic [3:0] t);
        case (t)
            MSG_HEARTBEAT: return "0";
            MSG_RESEND:    return "2";
            MSG_LOGOUT:    return "5";
            default:       return "A";
        endcase
    endfunction

    // Field terminator plus next tag: SOH, two tag digits, '='.
    function automatic logic [7:0] tag_suffix(input idx_t k, input logic [7:0] d0,
                                              input logic [7:0] d1);
        case (k)
            5'd0:    return SOH;
            5'd1:    return d0;
            5'd2:    return d1;
            default: return "=";
        endcase
    endfunction

endpackage

// File: rtl/fix_bin2dec3.sv
// Combinational 8-bit binary to three ASCII decimal digits (000..255).
module fix_bin2dec3 (
    input  logic [7:0] bin_i,
    output logic [7:0] hund_o,
    output logic [7:0] tens_o,
    output logic [7:0] ones_o
);
    logic [7:0] rem;

    always_comb begin
        hund_o = 8'h30 + bin_i / 8'd100;
        rem    = bin_i % 8'd100;
        tens_o = 8'h30 + rem / 8'd10;
        ones_o = 8'h30 + rem % 8'd10;
    end
endmodule

// File: rtl/fix_msg_tx.sv
// FIX session-message serializer: one request in, one tag=value byte stream out.
// Define FIX_LOGON_HBINT_EN to append "98=0|108=030|" to logon messages.
module fix_msg_tx
    import fix_msg_tx_pkg::*;
#(
    parameter int           VALUE_WIDTH = 128,
    parameter int           SIZE        = 5,
    parameter int           SENDER_LEN  = 3,
    parameter logic [127:0] SENDER_ID   = 128'h565253
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   initiate_msg_i,
    input  logic [3:0]             msg_type_i,
    input  logic [VALUE_WIDTH-1:0] target_comp_id_i,
    input  logic [SIZE-1:0]        s_v_target_comp_id_i,
    input  logic [23:0]            seq_bcd_i,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic                   tx_last_o,
    output logic                   busy_o,
    output logic                   seq_consume_o,
    output logic                   drop_o
);
    localparam int MAX_LEN = VALUE_WIDTH / 8;
    localparam int CW      = $clog2(MAX_LEN);

    state_t state_q, state_d;
    idx_t   idx_q, idx_d, seg_last;
    logic [7:0] cksum_q, cksum_d;
    logic       drop_q, drop_d, consume_q, consume_d;

    logic [3:0]             type_q, type_d;
    logic [VALUE_WIDTH-1:0] target_q, target_d;
    logic [SIZE-1:0]        len_q, len_d;
    logic [23:0]            seq_q, seq_d, blen_q, blen_d, ck_q, ck_d;

    logic       req_ok, accept, hs, seg_end;
    logic [7:0] body_len, bl_h, bl_t, bl_o, ck_h, ck_t, ck_o;
    logic [7:0] tgt_chr [MAX_LEN];
    logic [7:0] snd_chr [16];

    assign req_ok  = type_valid(msg_type_i) && (s_v_target_comp_id_i != '0) &&
                     (int'(s_v_target_comp_id_i) <= MAX_LEN);
    assign accept  = (state_q == ST_IDLE) && initiate_msg_i && req_ok;
    assign hs      = tx_valid_o && tx_ready_i;
    assign seg_end = hs && (idx_q == seg_last);

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) tgt_chr[i] = target_q[i*8 +: 8];
        for (int i = 0; i < 16; i++) snd_chr[i] = SENDER_ID[i*8 +: 8];
    end

    always_comb begin
        body_len = 8'(BODY_FIXED + SENDER_LEN) + 8'(len_q);
`ifdef FIX_LOGON_HBINT_EN
        if (type_q == MSG_LOGON) body_len = body_len + 8'(HBINT_LEN);
`endif
    end

    fix_bin2dec3 u_blen (.bin_i(body_len), .hund_o(bl_h), .tens_o(bl_t), .ones_o(bl_o));
    fix_bin2dec3 u_ck   (.bin_i(cksum_q),  .hund_o(ck_h), .tens_o(ck_t), .ones_o(ck_o));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cksum_q   <= '0;
            drop_q    <= 1'b0;
            consume_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cksum_q   <= cksum_d;
            drop_q    <= drop_d;
            consume_q <= consume_d;
        end
    end

    always_ff @(posedge clk) begin
        type_q   <= type_d;
        target_q <= target_d;
        len_q    <= len_d;
        seq_q    <= seq_d;
        blen_q   <= blen_d;
        ck_q     <= ck_d;
    end

    always_comb begin
        case (state_q)
            ST_BEGIN:  seg_last = idx_t'(BEGIN_LEN - 1);
            ST_SENDER: seg_last = idx_t'(SENDER_LEN + 3);
            ST_TARGET: seg_last = idx_t'(len_q) + 5'd3;
            ST_TYPE:   seg_last = 5'd4;
`ifdef FIX_LOGON_HBINT_EN
            ST_HBINT:  seg_last = idx_t'(HBINT_LEN - 1);
`endif
            default:   seg_last = 5'd6;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cksum_d   = cksum_q;
        drop_d    = initiate_msg_i && ((state_q != ST_IDLE) || !req_ok);
        consume_d = seg_end && (state_q == ST_CKSUM);
        if (hs) idx_d = seg_end ? '0 : idx_q + 5'd1;
        // Checksum covers everything up to the SOH before "10=".
        if (accept) cksum_d = '0;
        else if (hs && state_q != ST_CKSUM) cksum_d = cksum_q + tx_data_o;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_CALC;
            ST_CALC:   begin state_d = ST_BEGIN; idx_d = '0; end
            ST_BEGIN:  if (seg_end) state_d = ST_BLEN;
            ST_BLEN:   if (seg_end) state_d = ST_TYPE;
            ST_TYPE:   if (seg_end) state_d = ST_SENDER;
            ST_SENDER: if (seg_end) state_d = ST_TARGET;
            ST_TARGET: if (seg_end) state_d = ST_SEQ;
`ifdef FIX_LOGON_HBINT_EN
            ST_SEQ:    if (seg_end) state_d = (type_q == MSG_LOGON) ? ST_HBINT : ST_CKCALC;
            ST_HBINT:  if (seg_end) state_d = ST_CKCALC;
`else
            ST_SEQ:    if (seg_end) state_d = ST_CKCALC;
`endif
            ST_CKCALC: begin state_d = ST_CKSUM; idx_d = '0; end
            ST_CKSUM:  if (seg_end) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        type_d   = type_q;
        target_d = target_q;
        len_d    = len_q;
        seq_d    = seq_q;
        blen_d   = blen_q;
        ck_d     = ck_q;
        if (accept) begin
            type_d   = msg_type_i;
            target_d = target_comp_id_i;
            len_d    = s_v_target_comp_id_i;
            seq_d    = seq_bcd_i;
        end
        if (state_q == ST_CALC)   blen_d = {bl_o, bl_t, bl_h};
        if (state_q == ST_CKCALC) ck_d   = {ck_o, ck_t, ck_h};
    end

    always_comb begin
        tx_valid_o    = 1'b1;
        tx_data_o     = '0;
        tx_last_o     = 1'b0;
        busy_o        = (state_q != ST_IDLE);
        drop_o        = drop_q;
        seq_consume_o = consume_q;
        case (state_q)
            ST_BEGIN: tx_data_o = BEGIN_STR[idx_q[3:0]];
            ST_BLEN: begin
                case (idx_q)
                    5'd0: tx_data_o = blen_q[7:0];
                    5'd1: tx_data_o = blen_q[15:8];
                    5'd2: tx_data_o = blen_q[23:16];
                    default: tx_data_o = tag_suffix(idx_q - 5'd3, "3", "5");
                endcase
            end
            ST_TYPE: tx_data_o = (idx_q == 5'd0) ? msg_type_char(type_q)
                                                 : tag_suffix(idx_q - 5'd1, "4", "9");
            ST_SENDER: tx_data_o = (int'(idx_q) < SENDER_LEN) ? snd_chr[idx_q[3:0]]
                                 : tag_suffix(idx_q - idx_t'(SENDER_LEN), "5", "6");
            ST_TARGET: tx_data_o = (int'(idx_q) < int'(len_q)) ? tgt_chr[idx_q[CW-1:0]]
                                 : tag_suffix(idx_q - idx_t'(len_q), "3", "4");
            ST_SEQ: begin
                case (idx_q)
                    5'd0: tx_data_o = {4'h3, seq_q[23:20]};
                    5'd1: tx_data_o = {4'h3, seq_q[19:16]};
                    5'd2: tx_data_o = {4'h3, seq_q[15:12]};
                    5'd3: tx_data_o = {4'h3, seq_q[11:8]};
                    5'd4: tx_data_o = {4'h3, seq_q[7:4]};
                    5'd5: tx_data_o = {4'h3, seq_q[3:0]};
                    default: tx_data_o = SOH;
                endcase
            end
`ifdef FIX_LOGON_HBINT_EN
            ST_HBINT: tx_data_o = HBINT_STR[idx_q[3:0]];
`endif
            ST_CKSUM: begin
                case (idx_q)
                    5'd0: tx_data_o = "1";
                    5'd1: tx_data_o = "0";
                    5'd2: tx_data_o = "=";
                    5'd3: tx_data_o = ck_q[7:0];
                    5'd4: tx_data_o = ck_q[15:8];
                    5'd5: tx_data_o = ck_q[23:16];
                    default: tx_data_o = SOH;
                endcase
                tx_last_o = (idx_q == 5'd6);
            end
            default: tx_valid_o = 1'b0;
        endcase
    end
endmodule
